// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller: FSM state encoding, direction constants
// and floor mask helpers sized for the largest supported building (16 floors).
package elevator_pkg;

  localparam int MAX_FLOORS = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits strictly above idx; the double shift lets idx=15 wrap cleanly to an empty mask.
  function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [3:0] idx);
    return ~(((16'd1 << idx) << 1) - 16'd1);
  endfunction

  function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [3:0] idx);
    return (16'd1 << idx) - 16'd1;
  endfunction

endpackage

// File: rtl/elevator_tick_gen.sv
// Free-running motion tick: one-cycle pulse every TICK_DIV clk cycles, the first one
// on the TICK_DIV-th rising edge after reset release; never stalls.
module elevator_tick_gen #(
  parameter int TICK_DIV = 16777216
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// SCAN elevator controller: latches floor calls, moves one floor per tick, holds the door
// for DOOR_TICKS ticks. Outputs registered, decisions take effect on the edge a call arrives.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = 8,
  parameter int TICK_DIV   = 16777216,
  parameter int DOOR_TICKS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_FLOORS-1:0]         call_req,
  output logic [N_FLOORS-1:0]         floor_oh,
  output logic [$clog2(N_FLOORS)-1:0] floor_bin,
  output logic                        dir_up,
  output logic                        moving,
  output logic                        door_open,
  output logic [N_FLOORS-1:0]         pending
);

  localparam int FW = $clog2(N_FLOORS);
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_TICKS - 1);

  state_t              r_state;
  logic [FW-1:0]       r_cur;
  logic                r_dir_up;
  logic                r_moving;
  logic                r_door_open;
  logic [N_FLOORS-1:0] r_pending;
  logic [N_FLOORS-1:0] r_floor_oh;
  logic [DW-1:0]       r_door_cnt;

  logic                w_tick;
  logic [N_FLOORS-1:0] w_req;
  logic [FW-1:0]       w_cur_up;
  logic [FW-1:0]       w_cur_dn;
  logic                w_above;
  logic                w_below;
  logic                w_above_up;
  logic                w_below_dn;

  state_t              w_state_n;
  logic [FW-1:0]       w_cur_n;
  logic                w_dir_n;
  logic [DW-1:0]       w_door_cnt_n;
  logic [N_FLOORS-1:0] w_pending_n;
  logic [N_FLOORS-1:0] w_oh_n;

  elevator_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Calls arriving this edge count as outstanding so they can be acted on immediately.
  assign w_req    = r_pending | call_req;
  assign w_cur_up = r_cur + FW'(1);
  assign w_cur_dn = r_cur - FW'(1);

  assign w_above    = |(w_req & N_FLOORS'(above_mask(4'(r_cur))));
  assign w_below    = |(w_req & N_FLOORS'(below_mask(4'(r_cur))));
  assign w_above_up = |(w_req & N_FLOORS'(above_mask(4'(w_cur_up))));
  assign w_below_dn = |(w_req & N_FLOORS'(below_mask(4'(w_cur_dn))));

  always_comb begin
    w_state_n    = r_state;
    w_cur_n      = r_cur;
    w_dir_n      = r_dir_up;
    w_door_cnt_n = r_door_cnt;
    w_pending_n  = w_req;

    case (r_state)
      IDLE: begin
        if (w_req[r_cur]) begin
          w_state_n    = DOOR_OPEN;
          w_door_cnt_n = '0;
        end else if ((r_dir_up == DIR_UP) && w_above) begin
          w_state_n = MOVE_UP;
        end else if ((r_dir_up == DIR_DOWN) && w_below) begin
          w_state_n = MOVE_DOWN;
        end else if (w_above) begin
          w_dir_n   = DIR_UP;
          w_state_n = MOVE_UP;
        end else if (w_below) begin
          w_dir_n   = DIR_DOWN;
          w_state_n = MOVE_DOWN;
        end
      end

      MOVE_UP: begin
        if (r_cur == TOP_FLOOR) begin
          w_state_n = IDLE;
        end else if (w_tick) begin
          w_cur_n = w_cur_up;
          if (w_req[w_cur_up]) begin
            w_state_n    = DOOR_OPEN;
            w_door_cnt_n = '0;
          end else if (!w_above_up) begin
            w_state_n = IDLE;
          end
        end
      end

      MOVE_DOWN: begin
        if (r_cur == '0) begin
          w_state_n = IDLE;
        end else if (w_tick) begin
          w_cur_n = w_cur_dn;
          if (w_req[w_cur_dn]) begin
            w_state_n    = DOOR_OPEN;
            w_door_cnt_n = '0;
          end else if (!w_below_dn) begin
            w_state_n = IDLE;
          end
        end
      end

      DOOR_OPEN: begin
        // A fresh call for this floor keeps the door open rather than re-queueing it.
        if (call_req[r_cur]) begin
          w_door_cnt_n = '0;
        end else if (w_tick) begin
          if (r_door_cnt == DOOR_LAST) begin
            w_state_n = IDLE;
          end else begin
            w_door_cnt_n = r_door_cnt + DW'(1);
          end
        end
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase

    if (w_state_n == DOOR_OPEN) begin
      w_pending_n[w_cur_n] = 1'b0;
    end
  end

  assign w_oh_n = N_FLOORS'(1) << w_cur_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_dir_up    <= DIR_UP;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
      r_pending   <= '0;
      r_floor_oh  <= N_FLOORS'(1);
      r_door_cnt  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cur       <= w_cur_n;
      r_dir_up    <= w_dir_n;
      r_moving    <= (w_state_n == MOVE_UP) || (w_state_n == MOVE_DOWN);
      r_door_open <= (w_state_n == DOOR_OPEN);
      r_pending   <= w_pending_n;
      r_floor_oh  <= w_oh_n;
      r_door_cnt  <= w_door_cnt_n;
    end
  end

  assign floor_oh  = r_floor_oh;
  assign floor_bin = r_cur;
  assign dir_up    = r_dir_up;
  assign moving    = r_moving;
  assign door_open = r_door_open;
  assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_controller.sv
// Lockstep bench: a floor-level behavioural elevator model runs beside the DUT under
// directed SCAN scenarios and random call pulses; every cycle's outputs are compared.
module tb_elevator_controller;

  localparam int N  = 8;
  localparam int TD = 4;
  localparam int DT = 2;

  localparam int MD_IDLE = 0;
  localparam int MD_UP   = 1;
  localparam int MD_DOWN = 2;
  localparam int MD_DOOR = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] call_req;
  logic [N-1:0] floor_oh;
  logic [2:0]   floor_bin;
  logic         dir_up;
  logic         moving;
  logic         door_open;
  logic [N-1:0] pending;

  elevator_controller #(
    .N_FLOORS   (N),
    .TICK_DIV   (TD),
    .DOOR_TICKS (DT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .call_req  (call_req),
    .floor_oh  (floor_oh),
    .floor_bin (floor_bin),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int       m_floor;
  bit       m_up;
  int       m_mode;
  bit [7:0] m_pend;
  int       m_door_left;
  int       m_edges;

  int  door_q[$];
  int  door_cyc;
  bit  prev_door;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit calls_beyond(input bit [7:0] v, input int f, input bit up);
    for (int i = 0; i < N; i++)
      if (v[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_up = 1'b1; m_mode = MD_IDLE;
    m_pend = '0; m_door_left = 0; m_edges = 0;
  endtask

  task automatic open_door();
    m_mode = MD_DOOR;
    m_door_left = DT;
  endtask

  task automatic model_step(input bit [7:0] req);
    bit [7:0] want;
    bit tick;
    bit go_up;
    m_edges++;
    tick = (m_edges % TD) == 0;
    want = m_pend | req;
    case (m_mode)
      MD_IDLE: begin
        if (want[m_floor]) open_door();
        else if (calls_beyond(want, m_floor, m_up)) m_mode = m_up ? MD_UP : MD_DOWN;
        else if (calls_beyond(want, m_floor, !m_up)) begin
          m_up = !m_up;
          m_mode = m_up ? MD_UP : MD_DOWN;
        end
      end
      MD_UP, MD_DOWN: begin
        go_up = (m_mode == MD_UP);
        if (m_floor == (go_up ? N - 1 : 0)) m_mode = MD_IDLE;
        else if (tick) begin
          m_floor += go_up ? 1 : -1;
          if (want[m_floor]) open_door();
          else if (!calls_beyond(want, m_floor, go_up)) m_mode = MD_IDLE;
        end
      end
      default: begin
        if (req[m_floor]) m_door_left = DT;
        else if (tick) begin
          m_door_left--;
          if (m_door_left == 0) m_mode = MD_IDLE;
        end
      end
    endcase
    if (m_mode == MD_DOOR) want[m_floor] = 1'b0;
    m_pend = want;
  endtask

  task automatic compare_all();
    check("floor_bin", 32'(floor_bin), 32'(m_floor));
    check("floor_oh",  32'(floor_oh),  32'(1) << m_floor);
    check("pending",   32'(pending),   32'(m_pend));
    check("moving",    32'(moving),    32'(m_mode == MD_UP || m_mode == MD_DOWN));
    check("door_open", 32'(door_open), 32'(m_mode == MD_DOOR));
    check("dir_up",    32'(dir_up),    32'(m_up));
  endtask

  task automatic cycle(input logic [7:0] req);
    call_req = req;
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    compare_all();
    if (door_open && !prev_door) door_q.push_back(int'(floor_bin));
    if (door_open) door_cyc++;
    prev_door = door_open;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      cycle(8'h00);
      n++;
    end while (!(m_mode == MD_IDLE && m_pend == 0) && n < budget);
    check("settled_idle", {29'd0, moving, door_open, |pending}, 32'd0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; call_req = '0;
    prev_door = 1'b0; door_cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_floor_oh", 32'(floor_oh), 32'h01);
    check("rst_floor_bin", 32'(floor_bin), 32'd0);
    check("rst_dir_up", 32'(dir_up), 32'd1);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;

    // Single call to floor 5 from rest.
    door_cyc = 0; door_q.delete();
    cycle(8'h20);
    check("go_moving", 32'(moving), 32'd1);
    wait_idle(200);
    check("door_len_f5", 32'(door_cyc), 32'd8);
    check("door_floor_f5", (door_q.size() > 0) ? 32'(door_q[0]) : 32'hFF, 32'd5);

    // Travel to floor 3, then a call for the current floor opens the door next edge.
    cycle(8'h08);
    wait_idle(200);
    cycle(8'h08);
    check("same_floor_door", 32'(door_open), 32'd1);
    check("same_floor_oh", 32'(floor_oh), 32'h08);
    check("same_floor_pend", 32'(pending[3]), 32'd0);
    wait_idle(200);

    // SCAN ordering: heading up past 4 with 7 queued, add 6 and 2.
    cycle(8'h80);
    for (int i = 0; i < 100 && !(m_floor == 4 && m_mode == MD_UP); i++) cycle(8'h00);
    check("at_f4_up", {28'd0, moving, floor_bin}, {28'd0, 1'b1, 3'd4});
    door_q.delete();
    cycle(8'h44);
    wait_idle(400);
    check("scan_cnt", 32'(door_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("scan_order", (i < door_q.size()) ? 32'(door_q[i]) : 32'hFF, (i == 0) ? 32'd6 : (i == 1) ? 32'd7 : 32'd2);

    // Door at the top floor held open by a continuous call.
    cycle(8'h80);
    for (int i = 0; i < 200 && m_mode != MD_DOOR; i++) cycle(8'h00);
    for (int i = 0; i < 20; i++) cycle(8'h80);
    check("hold_door", 32'(door_open), 32'd1);
    check("hold_pend7", 32'(pending[7]), 32'd0);
    check("hold_floor", 32'(floor_bin), 32'd7);
    wait_idle(200);

    // Asynchronous reset while travelling down between floors 3 and 2.
    cycle(8'h01);
    for (int i = 0; i < 200 && !(m_floor == 3 && m_mode == MD_DOWN); i++) cycle(8'h00);
    #2 rst = 1'b1;
    #1;
    check("arst_floor_oh", 32'(floor_oh), 32'h01);
    check("arst_pending", 32'(pending), 32'h00);
    check("arst_moving", 32'(moving), 32'd0);
    model_reset();
    prev_door = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // All floors called at once from floor 0.
    door_q.delete();
    cycle(8'hFF);
    wait_idle(600);
    check("all_cnt", 32'(door_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check("all_order", (i < door_q.size()) ? 32'(door_q[i]) : 32'hFF, 32'(i));
    check("all_dir_up", 32'(dir_up), 32'd1);

    // Random call pulses.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00);
    wait_idle(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
